// File: rtl/pht_gshare_pkg.sv
// Shared types and helpers for the gshare pattern history table.
// Helpers work on 32-bit words; callers cast to their own widths.
package pht_gshare_pkg;

  localparam int unsigned PHT_FN_W = 32;

  typedef logic [PHT_FN_W-1:0] pht_word_t;

  typedef enum logic {
    PHT_INIT  = 1'b0,
    PHT_READY = 1'b1
  } pht_state_e;

  function automatic pht_word_t pht_mask(input int unsigned w);
    if (w >= PHT_FN_W) return '1;
    return (pht_word_t'(1) << w) - pht_word_t'(1);
  endfunction

  // Weakly not-taken: one below the counter midpoint
  function automatic pht_word_t pht_init_val(input int unsigned ctr_width);
    return (pht_word_t'(1) << (ctr_width - 1)) - pht_word_t'(1);
  endfunction

  function automatic pht_word_t pht_sat_next(input pht_word_t ctr, input logic taken,
                                             input int unsigned ctr_width);
    pht_word_t max_val;
    max_val = pht_mask(ctr_width);
    if (taken) return (ctr == max_val) ? ctr : ctr + pht_word_t'(1);
    return (ctr == '0) ? ctr : ctr - pht_word_t'(1);
  endfunction

  function automatic pht_word_t pht_hash(input pht_word_t pc, input pht_word_t ghr,
                                         input int unsigned index_width);
    return (pc ^ ghr) & pht_mask(index_width);
  endfunction

endpackage

// File: rtl/pht_gshare_if.sv
// Fetch/execute-facing bus of the gshare PHT: prediction, resolution, flush and debug.
interface pht_gshare_if #(
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned CTR_WIDTH   = 2,
  parameter int unsigned HIST_WIDTH  = 4,
  parameter int unsigned ADDR_WIDTH  = 8
);
  logic                   flush;
  logic                   ready;
  logic                   pred_valid;
  logic [ADDR_WIDTH-1:0]  pred_pc;
  logic                   pred_taken;
  logic [INDEX_WIDTH-1:0] pred_index;
  logic [HIST_WIDTH-1:0]  pred_ghr;
  logic                   upd_valid;
  logic [INDEX_WIDTH-1:0] upd_index;
  logic                   upd_taken;
  logic                   upd_mispredict;
  logic [HIST_WIDTH-1:0]  upd_ghr;
  logic [HIST_WIDTH-1:0]  ghr;
  logic [INDEX_WIDTH-1:0] dbg_index;
  logic [CTR_WIDTH-1:0]   dbg_ctr;

  modport master (
    output flush, pred_valid, pred_pc, upd_valid, upd_index, upd_taken,
           upd_mispredict, upd_ghr, dbg_index,
    input  ready, pred_taken, pred_index, pred_ghr, ghr, dbg_ctr
  );

  modport slave (
    input  flush, pred_valid, pred_pc, upd_valid, upd_index, upd_taken,
           upd_mispredict, upd_ghr, dbg_index,
    output ready, pred_taken, pred_index, pred_ghr, ghr, dbg_ctr
  );
endinterface

// File: rtl/pht_gshare_ghr.sv
// Global history register: speculative shift on prediction, restore on mispredict,
// cleared by flush. Priority: flush > restore > speculative shift.
module pht_gshare_ghr #(
  parameter int unsigned HIST_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  spec_en,
  input  logic                  spec_bit,
  input  logic                  rec_en,
  input  logic [HIST_WIDTH-1:0] rec_ghr,
  input  logic                  rec_bit,
  output logic [HIST_WIDTH-1:0] ghr
);

  logic [HIST_WIDTH-1:0] ghr_d;

  // Shift by concatenating and truncating the oldest bit; also covers HIST_WIDTH=1
  always_comb begin
    ghr_d = ghr;
    if (flush)        ghr_d = '0;
    else if (rec_en)  ghr_d = HIST_WIDTH'({rec_ghr, rec_bit});
    else if (spec_en) ghr_d = HIST_WIDTH'({ghr, spec_bit});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ghr <= '0;
    else        ghr <= ghr_d;
  end

endmodule

// File: rtl/pht_gshare.sv
// Gshare pattern history table with init sweep, internal saturating update and GHR.
// Optional same-cycle update forwarding: define PHT_GSHARE_BYPASS_EN.
module pht_gshare
  import pht_gshare_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned CTR_WIDTH   = 2,
  parameter int unsigned HIST_WIDTH  = 4,
  parameter int unsigned ADDR_WIDTH  = 8
) (
  input logic         clk,
  input logic         rst_n,
  pht_gshare_if.slave bus
);

  localparam int unsigned            DEPTH    = 1 << INDEX_WIDTH;
  localparam logic [CTR_WIDTH-1:0]   INIT_VAL = CTR_WIDTH'(pht_init_val(CTR_WIDTH));
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(DEPTH - 1);

  pht_state_e             state_q, state_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic                   ready_q, ready_d;
  logic [CTR_WIDTH-1:0]   tbl [DEPTH];

  logic                   tbl_we;
  logic [INDEX_WIDTH-1:0] tbl_widx;
  logic [CTR_WIDTH-1:0]   tbl_wdata;

  logic [ADDR_WIDTH-1:0]  pc;
  logic [HIST_WIDTH-1:0]  ghr_q;
  logic [INDEX_WIDTH-1:0] look_idx;
  logic [CTR_WIDTH-1:0]   look_ctr;
  logic [CTR_WIDTH-1:0]   dbg_val;
  logic                   look_taken;
  logic                   upd_en;
  logic [CTR_WIDTH-1:0]   upd_new;

  assign pc       = bus.pred_pc;
  assign upd_en   = ready_q && bus.upd_valid && !bus.flush;
  assign upd_new  = CTR_WIDTH'(pht_sat_next(pht_word_t'(tbl[bus.upd_index]), bus.upd_taken,
                                            CTR_WIDTH));
  assign look_idx = INDEX_WIDTH'(pht_hash(pht_word_t'(pc), pht_word_t'(ghr_q), INDEX_WIDTH));

  // Lookup and debug read, with optional forwarding of a colliding update
  always_comb begin
    look_ctr = tbl[look_idx];
    dbg_val  = tbl[bus.dbg_index];
`ifdef PHT_GSHARE_BYPASS_EN
    if (upd_en && bus.pred_valid && (bus.upd_index == look_idx)) begin
      look_ctr = upd_new;
      if (bus.dbg_index == bus.upd_index) dbg_val = upd_new;
    end
`endif
  end

  assign look_taken     = ready_q & look_ctr[CTR_WIDTH-1];
  assign bus.pred_taken = look_taken;
  assign bus.pred_index = look_idx;
  assign bus.pred_ghr   = ghr_q;
  assign bus.ghr        = ghr_q;
  assign bus.ready      = ready_q;
  assign bus.dbg_ctr    = ready_q ? dbg_val : '0;

  // Next state, sweep pointer and the single table write port
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ready_d   = ready_q;
    tbl_we    = 1'b0;
    tbl_widx  = bus.upd_index;
    tbl_wdata = upd_new;
    case (state_q)
      PHT_INIT: begin
        tbl_we    = 1'b1;
        tbl_widx  = ptr_q;
        tbl_wdata = INIT_VAL;
        ptr_d     = ptr_q + INDEX_WIDTH'(1);
        if (ptr_q == LAST_IDX) begin
          state_d = PHT_READY;
          ready_d = 1'b1;
        end
      end
      PHT_READY: tbl_we = upd_en;
      default:   state_d = PHT_INIT;
    endcase
    if (bus.flush) begin
      state_d = PHT_INIT;
      ptr_d   = '0;
      ready_d = 1'b0;
      tbl_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PHT_INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  // Table contents are undefined until the sweep completes, so no reset
  always_ff @(posedge clk) begin
    if (tbl_we) tbl[tbl_widx] <= tbl_wdata;
  end

  pht_gshare_ghr #(.HIST_WIDTH(HIST_WIDTH)) u_ghr (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.flush),
    .spec_en  (ready_q && bus.pred_valid),
    .spec_bit (look_taken),
    .rec_en   (ready_q && bus.upd_valid && bus.upd_mispredict),
    .rec_ghr  (bus.upd_ghr),
    .rec_bit  (bus.upd_taken),
    .ghr      (ghr_q)
  );

endmodule

// File: tb/tb_pht_gshare.sv
// Self-checking bench for pht_gshare: directed plan items plus random traffic
// against a table/history model. Honours PHT_GSHARE_BYPASS_EN.
module tb_pht_gshare;

  localparam int DEPTH = 16;
  localparam int CMAX  = 3;
  localparam int HALF  = 2;
  localparam int INIT  = 1;
`ifdef PHT_GSHARE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  typedef struct {
    int pt;
    int idx;
    int pghr;
    int dbg;
  } obs_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  int   m_tbl [DEPTH];
  int   m_ghr;
  bit   m_ready;
  int   m_sweep;

  pht_gshare_if #(.INDEX_WIDTH(4), .CTR_WIDTH(2), .HIST_WIDTH(4), .ADDR_WIDTH(8)) bus ();

  pht_gshare dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_sweep = 0;
    m_ghr   = 0;
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model at posedge
  task automatic step(input bit f, input bit pv, input int pc, input bit uv, input int ui,
                      input bit ut, input bit um, input int ug, input int di, output obs_t o);
    int idx, upd_new, look, dbgv, exp_pt;
    bit upd_en;
    @(negedge clk);
    bus.flush          = f;
    bus.pred_valid     = pv;
    bus.pred_pc        = 8'(pc);
    bus.upd_valid      = uv;
    bus.upd_index      = 4'(ui);
    bus.upd_taken      = ut;
    bus.upd_mispredict = um;
    bus.upd_ghr        = 4'(ug);
    bus.dbg_index      = 4'(di);
    #1;
    idx     = (pc % 16) ^ m_ghr;
    upd_en  = m_ready && uv && !f;
    upd_new = ut ? ((m_tbl[ui] < CMAX) ? m_tbl[ui] + 1 : CMAX)
                 : ((m_tbl[ui] > 0) ? m_tbl[ui] - 1 : 0);
    look    = m_tbl[idx];
    dbgv    = m_tbl[di];
    if (BYP == 1 && upd_en && pv && ui == idx) begin
      look = upd_new;
      if (di == ui) dbgv = upd_new;
    end
    exp_pt = (m_ready && look >= HALF) ? 1 : 0;
    if (!m_ready) dbgv = 0;
    o.pt   = int'(bus.pred_taken);
    o.idx  = int'(bus.pred_index);
    o.pghr = int'(bus.pred_ghr);
    o.dbg  = int'(bus.dbg_ctr);
    check_eq("ready", int'(bus.ready), int'(m_ready));
    check_eq("ghr", int'(bus.ghr), m_ghr);
    check_eq("pred_index", o.idx, idx);
    check_eq("pred_ghr", o.pghr, m_ghr);
    check_eq("pred_taken", o.pt, exp_pt);
    check_eq("dbg_ctr", o.dbg, dbgv);
    @(posedge clk);
    if (f) begin
      model_reset();
    end else if (!m_ready) begin
      m_sweep++;
      if (m_sweep == DEPTH) begin
        m_ready = 1'b1;
        foreach (m_tbl[i]) m_tbl[i] = INIT;
      end
    end else begin
      if (uv) m_tbl[ui] = upd_new;
      if (uv && um)  m_ghr = (ug * 2 + int'(ut)) % 16;
      else if (pv)   m_ghr = (m_ghr * 2 + exp_pt) % 16;
    end
  endtask

  task automatic idle(input int di, output obs_t o);
    step(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, di, o);
  endtask

  initial begin
    obs_t o;
    int   sat_exp [7] = '{2, 3, 3, 2, 1, 0, 0};
    n_checks = 0;
    n_fail   = 0;
    bus.flush = 1'b0; bus.pred_valid = 1'b0; bus.pred_pc = '0;
    bus.upd_valid = 1'b0; bus.upd_index = '0; bus.upd_taken = 1'b0;
    bus.upd_mispredict = 1'b0; bus.upd_ghr = '0; bus.dbg_index = '0;
    foreach (m_tbl[i]) m_tbl[i] = 0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", int'(bus.ready), 0);
    check_eq("rst_ghr", int'(bus.ghr), 0);
    check_eq("rst_pred_taken", int'(bus.pred_taken), 0);
    check_eq("rst_dbg_ctr", int'(bus.dbg_ctr), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Sweep: predictions read 0, updates ignored, ready after exactly 16 cycles
    for (int c = 0; c < DEPTH; c++) begin
      step(1'b0, 1'b1, int'($urandom % 256), 1'b1, int'($urandom % 16), 1'b1, 1'b0, 0, c, o);
      check_eq("sweep_pred_taken", o.pt, 0);
    end
    #1 check_eq("ready_latency", int'(bus.ready), 1);
    for (int i = 0; i < DEPTH; i++) begin
      idle(i, o);
      check_eq("init_val", o.dbg, INIT);
    end

    // Saturation on index 5
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 0, 1'b1, 5, i < 3, 1'b0, 0, 5, o);
      #1 check_eq("sat_seq", int'(bus.dbg_ctr), sat_exp[i]);
    end

    // Restore GHR to 1010 through a not-taken mispredict, then hash a prediction
    step(1'b0, 1'b0, 0, 1'b1, 15, 1'b0, 1'b1, 5, 0, o);
    #1 check_eq("ghr_restore", int'(bus.ghr), 10);
    step(1'b0, 1'b1, 3, 1'b0, 0, 1'b0, 1'b0, 0, 9, o);
    check_eq("hash_index", o.idx, 9);
    check_eq("hash_pred_ghr", o.pghr, 10);
    check_eq("hash_pred_taken", o.pt, 0);
    #1 check_eq("ghr_spec_shift", int'(bus.ghr), 4);

    // Recovery overrides the same-cycle speculative shift
    step(1'b0, 1'b1, int'($urandom % 256), 1'b1, 3, 1'b1, 1'b1, 3, 0, o);
    #1 check_eq("ghr_recovery", int'(bus.ghr), 7);

    // Same-index collision on entry 2 (value 1): pc 5 ^ ghr 0111 = 2
    step(1'b0, 1'b1, 5, 1'b1, 2, 1'b1, 1'b0, 0, 2, o);
    check_eq("collide_index", o.idx, 2);
    check_eq("collide_pred_taken", o.pt, BYP);
    check_eq("collide_dbg", o.dbg, BYP == 1 ? 2 : 1);
    #1 check_eq("collide_after", int'(bus.dbg_ctr), 2);

    // Train, then flush together with prediction and update
    for (int i = 0; i < 20; i++)
      step(1'b0, $urandom % 2 == 1, int'($urandom % 256), 1'b1, int'($urandom % 16),
           $urandom % 4 != 0, $urandom % 4 == 0, int'($urandom % 16), int'($urandom % 16), o);
    step(1'b1, 1'b1, int'($urandom % 256), 1'b1, 7, 1'b1, 1'b1, 15, 7, o);
    #1;
    check_eq("flush_ready", int'(bus.ready), 0);
    check_eq("flush_ghr", int'(bus.ghr), 0);
    for (int c = 0; c < DEPTH; c++)
      step(1'b0, 1'b1, int'($urandom % 256), 1'b1, int'($urandom % 16), $urandom % 2 == 1,
           $urandom % 2 == 1, int'($urandom % 16), c, o);
    #1 check_eq("flush_resweep", int'(bus.ready), 1);
    for (int i = 0; i < DEPTH; i++) begin
      idle(i, o);
      check_eq("flush_init_val", o.dbg, INIT);
    end

    // Random traffic with occasional flushes
    for (int n = 0; n < 600; n++) begin
      int ui, di;
      ui = int'($urandom % 16);
      di = ($urandom % 2 == 1) ? ui : int'($urandom % 16);
      step($urandom % 64 == 0, $urandom % 4 != 0, int'($urandom % 256), $urandom % 3 != 0, ui,
           $urandom % 2 == 1, $urandom % 5 == 0, int'($urandom % 16), di, o);
    end

    // Asynchronous reset in mid-operation
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_rst_ready", int'(bus.ready), 0);
    check_eq("async_rst_ghr", int'(bus.ghr), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < DEPTH + 4; c++) idle(c % 16, o);
    #1 check_eq("async_rst_ready_again", int'(bus.ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
